mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have ports: start input 1 (request); op_a input 64 (multiplicand); op_b input 64 (multiplier); ready output 1 (idle, can accept); busy output 1.
REQ-003 SHALL have ports: done output 1 (one-cycle completion pulse); result output 64 (low 64 bits of unsigned product); ovf output 1 (product truncated).
REQ-004 SHALL have ports: alu_a output 64; alu_b output 64; alu_control output 2; alu_out input 64; alu_cout input 1 (carry out of bit 63 of the shared 64-bit ALU).
REQ-005 SHALL have ports, present only with MUL_SEQ_CC_EN: zf output 1; sf output 1; of output 1.

Function
REQ-006 SHALL implement FSM states IDLE, ITER, DONE; ready=1 only in IDLE; busy=1 in ITER and DONE.
REQ-007 SHALL, in IDLE with start=1, load acc=0, mcand=op_a, mplier=op_b, cnt=0, ovf_acc=0, lost=0; next state ITER if op_b!=0, else DONE.
REQ-008 SHALL ignore start outside IDLE; operands are sampled only on the accepting edge.
REQ-009 SHALL drive, in every state, alu_a=acc, alu_b=mcand, alu_control=ALU_ADD.
REQ-010 SHALL, in each ITER cycle with mplier[0]=1: acc<=alu_out; ovf_acc<=ovf_acc|alu_cout|lost.
REQ-011 SHALL, in each ITER cycle: mcand<=mcand<<1; lost<=lost|mcand[63]; mplier<=mplier>>1; cnt<=cnt+1 (7-bit).
REQ-012 SHALL leave ITER for DONE when the shifted mplier is zero or cnt==63; otherwise remain in ITER.
REQ-013 SHALL, in DONE, assert done for exactly one cycle, drive result=acc and ovf=ovf_acc, then return to IDLE.
REQ-014 SHALL hold result and ovf stable from DONE until the next DONE.
REQ-015 SHALL have latency from the accepting edge to done: 1 cycle if op_b==0, otherwise m+2 cycles (m = index of highest set bit of op_b); maximum 65.
REQ-016 SHALL accept start in the IDLE cycle directly following DONE (back-to-back operation).

Reset
REQ-017 SHALL, on rst=1 at a clock edge (including mid-operation): state=IDLE; acc, mcand, mplier, cnt, result=0; done=0; ovf, lost, ovf_acc=0; zf, sf, of=0.
REQ-018 SHALL let rst take priority over start in the same cycle.

Configuration
REQ-019 SHALL, with MUL_SEQ_CC_EN defined, register zf=(acc==0), sf=acc[63], of=ovf_acc in DONE, hold them until the next DONE, and clear them on reset.
REQ-020 SHALL, without MUL_SEQ_CC_EN, omit zf/sf/of ports and logic; all other behaviour is identical.

Structure
REQ-021 SHALL take from shared package alu_pkg: ALU op encoding ALU_AND=2'd0, ALU_XOR=2'd1, ALU_ADD=2'd2, ALU_SUB=2'd3; FSM state enum; WORD_W=64.
REQ-022 SHALL contain no ALU of its own; the ALU is external and shared. One sub-module is natural: mul_seq_fsm (state register and next-state logic). Datapath registers stay in mul_seq.

Verification
REQ-023 SHALL pass: start, op_a=3, op_b=5 -> done 4 cycles after accept; result=15; ovf=0; zf=0, sf=0.
REQ-024 SHALL pass: start, op_a=7, op_b=0 -> done 1 cycle after accept; result=0; zf=1.
REQ-025 SHALL pass: op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2 -> done at +3; result=64'hFFFF_FFFF_FFFF_FFFE; ovf=1; sf=1.
REQ-026 SHALL pass: op_a=1, op_b=64'h8000_0000_0000_0000 -> done at +65; result=64'h8000_0000_0000_0000; ovf=0.
REQ-027 SHALL pass: rst asserted during ITER of 3*5 -> next cycle ready=1, done=0, result=0; a following 2*2 yields 4.
REQ-028 SHALL pass: start held high continuously -> accepted only in IDLE; done pulses never overlap an accept; second result correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: operation encoding for the external 64-bit ALU,
// the word width, and the sequential multiplier's FSM state type.
package alu_pkg;

    localparam int WORD_W = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_XOR = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq_fsm.sv
// Control FSM of the shift-and-add multiplier: IDLE -> ITER* -> DONE -> IDLE.
// The state is an output so the top-level datapath and any checker can see it.
module mul_seq_fsm
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op_b_zero,
    input  logic       iter_last,
    output mul_state_e state,
    output logic       ready,
    output logic       busy,
    output logic       done
);

    mul_state_e state_nxt;

    // State register; synchronous reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero multiplier skips ITER and completes immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = op_b_zero ? DONE : ITER;
                end
            end
            ITER: begin
                if (iter_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == ITER) || (state == DONE);
        done  = (state == DONE);
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 64x64 unsigned multiplier (low 64 product bits) built on an
// external, shared 64-bit ALU that is always asked to compute acc + mcand.
// Optional condition codes zf/sf/of are enabled with `define MUL_SEQ_CC_EN.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (ready is high only in IDLE); op_a/op_b are sampled on that edge
// only. start is ignored while busy. done is a one-cycle pulse, and
// result/ovf (and zf/sf/of) stay valid from that pulse until the next one.
module mul_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              ovf,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [1:0]        alu_control,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              alu_cout
`ifdef MUL_SEQ_CC_EN
    ,
    output logic              zf,
    output logic              sf,
    output logic              of
`endif
);

    mul_state_e        state;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] mcand;
    logic [WORD_W-1:0] mplier;
    logic [WORD_W-1:0] mplier_shr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;
    logic              lost;
    logic [WORD_W-1:0] result_q;
    logic              ovf_q;
    logic              iter_last;

    // Iteration ends once no multiplier bits remain, or after the 64th bit.
    assign mplier_shr = mplier >> 1;
    assign iter_last  = (mplier_shr == '0) || (cnt == 7'd63);

    mul_seq_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_b_zero (op_b == '0),
        .iter_last (iter_last),
        .state     (state),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    // The shared ALU request is constant: accumulate the shifted multiplicand.
    assign alu_a       = acc;
    assign alu_b       = mcand;
    assign alu_control = ALU_ADD;

    // Datapath: load on accept, shift-and-add in ITER, capture results in DONE.
    // lost records multiplicand bits shifted off the top; adding a truncated
    // multiplicand means the true product no longer fits in 64 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            lost     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        mcand   <= op_a;
                        mplier  <= op_b;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        lost    <= 1'b0;
                    end
                end
                ITER: begin
                    if (mplier[0]) begin
                        acc     <= alu_out;
                        ovf_acc <= ovf_acc | alu_cout | lost;
                    end
                    mcand  <= mcand << 1;
                    lost   <= lost | mcand[WORD_W-1];
                    mplier <= mplier_shr;
                    cnt    <= cnt + 7'd1;
                end
                DONE: begin
                    result_q <= acc;
                    ovf_q    <= ovf_acc;
                end
                default: ;
            endcase
        end
    end

    // In DONE the live accumulator is presented; afterwards the captured copy.
    assign result = (state == DONE) ? acc     : result_q;
    assign ovf    = (state == DONE) ? ovf_acc : ovf_q;

`ifdef MUL_SEQ_CC_EN
    logic zf_q;
    logic sf_q;
    logic of_q;

    // Condition codes are captured alongside result and held until next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (state == DONE) begin
            zf_q <= (acc == '0);
            sf_q <= acc[WORD_W-1];
            of_q <= ovf_acc;
        end
    end

    assign zf = (state == DONE) ? (acc == '0)     : zf_q;
    assign sf = (state == DONE) ? acc[WORD_W-1]   : sf_q;
    assign of = (state == DONE) ? ovf_acc         : of_q;
`endif

endmodule
